// File: rtl/im_loader_ctrl.sv
// Instruction-memory load controller: byte stream in, big-endian 32-bit words out, CPU reset held during load.
// Optional trailing XOR checksum byte and CHK state when IM_LOADER_CHECKSUM_EN is defined.
module im_loader_ctrl #(
  parameter int AW       = 7,
  parameter bit AUTO_RUN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [31:0]   im_wdata,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
`ifdef IM_LOADER_CHECKSUM_EN
    S_CHK  = 2'd2,
`endif
    S_RUN  = 2'd3
  } state_t;

  localparam state_t RESET_STATE = AUTO_RUN ? S_RUN : S_IDLE;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_byte_cnt;
  logic [AW:0]   r_len;
  logic [AW:0]   r_words;
  logic [AW-1:0] r_addr;
  logic [23:0]   r_shift;
  logic          r_err;
  logic          w_accept;
  logic          w_start;
  logic          w_word_done;
  logic          w_last_word;
  logic [AW:0]   w_words_inc;

`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  assign byte_ready = (r_state == S_LOAD) || (r_state == S_CHK);
  assign err        = r_err;
`else
  assign byte_ready = (r_state == S_LOAD);
  assign err        = 1'b0;
`endif

  assign busy        = byte_ready;
  assign w_accept    = byte_valid && byte_ready;
  assign w_start     = load_start && ((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_word_done = (r_state == S_LOAD) && w_accept && (r_byte_cnt == 2'd3);
  assign w_words_inc = r_words + 1'b1;
  assign w_last_word = w_word_done && (w_words_inc == r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RESET_STATE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN: if (load_start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_RUN;
`endif
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK: if (w_accept) w_next = (byte_data == r_csum) ? S_RUN : S_IDLE;
`endif
      default: w_next = RESET_STATE;
    endcase
  end

  // NOTE: every register here uses <= so all of them sample the same pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_len      <= '0;
      r_words    <= '0;
      r_addr     <= '0;
      r_shift    <= '0;
      r_err      <= 1'b0;
      im_we      <= 1'b0;
      im_waddr   <= '0;
      im_wdata   <= '0;
      done       <= 1'b0;
      cpu_rst    <= 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      im_we   <= w_word_done;
      done    <= (w_next == S_RUN) && (r_state != S_RUN);
      cpu_rst <= (w_next != S_RUN);
      if (w_word_done) begin
        im_waddr <= r_addr;
        im_wdata <= {r_shift, byte_data};
      end
      if (w_start) begin
        r_len      <= (load_len == '0) ? {1'b1, {AW{1'b0}}} : load_len;
        r_byte_cnt <= '0;
        r_words    <= '0;
        r_addr     <= '0;
        r_err      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
        r_csum     <= '0;
`endif
      end else if ((r_state == S_LOAD) && w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_shift    <= {r_shift[15:0], byte_data};
`ifdef IM_LOADER_CHECKSUM_EN
        r_csum     <= r_csum ^ byte_data;
`endif
        if (r_byte_cnt == 2'd3) begin
          r_addr  <= r_addr + 1'b1;
          r_words <= w_words_inc;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      else if ((r_state == S_CHK) && w_accept && (byte_data != r_csum)) begin
        r_err <= 1'b1;
      end
`endif
    end
  end

endmodule
